// File: rtl/amx_link_pkg.sv
`default_nettype none
// ============================================================================
// Module  : amx_link_pkg
// Brief   : Shared constants and link-state encoding for the AMX byte link.
// Revision: 1.0 - initial release
// ============================================================================
package amx_link_pkg;

    localparam logic [7:0] c_sof_byte        = 8'hA5;
    localparam int         c_default_max_len = 16;

    typedef enum logic [2:0] {
        ST_FILL = 3'd0,
        ST_SOF  = 3'd1,
        ST_LEN  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CSUM = 3'd4
    } link_state_e;

endpackage
`default_nettype wire

// File: rtl/amx_frame_buf.sv
`default_nettype none
// ============================================================================
// Module  : amx_frame_buf
// Brief   : MAX_LEN x 8 frame buffer with write pointer (count) and read pointer.
// Revision: 1.0 - initial release
// ============================================================================
module amx_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int PW      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_wr_en,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd_inc,
    output logic [PW-1:0] o_count,
    output logic [PW-1:0] o_rd,
    output logic [7:0]    o_rd_data
);

    logic [7:0]    r_mem [MAX_LEN];
    logic [PW-1:0] r_count;
    logic [PW-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_rd    <= '0;
        end else if (i_clr) begin
            r_count <= '0;
            r_rd    <= '0;
        end else begin
            if (i_wr_en)  r_count <= r_count + PW'(1);
            if (i_rd_inc) r_rd    <= r_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (r_count == PW'(i)) r_mem[i] <= i_wr_data;
            end
        end
    end

    // Read pointer may sit one past the last entry; that slot reads as zero.
    always_comb begin
        o_rd_data = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_rd == PW'(i)) o_rd_data = r_mem[i];
        end
    end

    assign o_count = r_count;
    assign o_rd    = r_rd;

endmodule
`default_nettype wire

// File: rtl/amx_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : amx_frame_tx
// Brief   : AMX link transmitter: buffers a frame, sends SOF, LEN, payload and,
//           with AMX_FRAME_TX_CSUM_EN defined, a trailing XOR checksum byte.
// Revision: 1.0 - initial release
// ============================================================================
module amx_frame_tx
    import amx_link_pkg::*;
#(
    parameter int         MAX_LEN  = c_default_max_len,
    parameter logic [7:0] SOF_BYTE = c_sof_byte
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       trunc
);

    localparam int            PW         = $clog2(MAX_LEN + 1);
    localparam logic [PW-1:0] c_last_idx = PW'(MAX_LEN - 1);

    link_state_e   r_state;
    link_state_e   w_state_nxt;
    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data_nxt;
    logic          r_tx_valid;
    logic          w_tx_valid_nxt;
    logic          r_trunc;
    logic          w_trunc_nxt;
    logic          w_wr_en;
    logic          w_rd_inc;
    logic          w_clr;
    logic          w_close;
    logic [PW-1:0] w_count;
    logic [PW-1:0] w_rd;
    logic [7:0]    w_rd_data;
    logic [7:0]    w_len;

    amx_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .PW      (PW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_wr_en   (w_wr_en),
        .i_wr_data (in_data),
        .i_rd_inc  (w_rd_inc),
        .o_count   (w_count),
        .o_rd      (w_rd),
        .o_rd_data (w_rd_data)
    );

    assign w_len = 8'(w_count);

`ifdef AMX_FRAME_TX_CSUM_EN
    logic [7:0] r_csum;
    logic [7:0] w_len_close;

    // Count has not yet absorbed the closing byte, so the seed is count+1.
    assign w_len_close = w_len + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n || w_clr) begin
            r_csum <= 8'h00;
        end else if (w_wr_en) begin
            r_csum <= r_csum ^ in_data ^ (w_close ? w_len_close : 8'h00);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_trunc    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_trunc    <= w_trunc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_trunc_nxt    = 1'b0;
        w_wr_en        = 1'b0;
        w_rd_inc       = 1'b0;
        w_clr          = 1'b0;
        w_close        = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    w_close = in_last || (w_count == c_last_idx);
                    if (w_close) begin
                        w_state_nxt    = ST_SOF;
                        w_tx_valid_nxt = 1'b1;
                        w_tx_data_nxt  = SOF_BYTE;
                        w_trunc_nxt    = !in_last;
                    end
                end
            end
            ST_SOF: begin
                if (tx_ready) begin
                    w_state_nxt   = ST_LEN;
                    w_tx_data_nxt = w_len;
                end
            end
            ST_LEN: begin
                if (tx_ready) begin
                    w_state_nxt   = ST_PAY;
                    w_tx_data_nxt = w_rd_data;
                    w_rd_inc      = 1'b1;
                end
            end
            ST_PAY: begin
                // rd counts bytes already loaded into the output register.
                if (tx_ready) begin
                    if (w_rd == w_count) begin
`ifdef AMX_FRAME_TX_CSUM_EN
                        w_state_nxt   = ST_CSUM;
                        w_tx_data_nxt = r_csum;
`else
                        w_state_nxt    = ST_FILL;
                        w_tx_valid_nxt = 1'b0;
                        w_tx_data_nxt  = 8'h00;
                        w_clr          = 1'b1;
`endif
                    end else begin
                        w_tx_data_nxt = w_rd_data;
                        w_rd_inc      = 1'b1;
                    end
                end
            end
`ifdef AMX_FRAME_TX_CSUM_EN
            ST_CSUM: begin
                if (tx_ready) begin
                    w_state_nxt    = ST_FILL;
                    w_tx_valid_nxt = 1'b0;
                    w_tx_data_nxt  = 8'h00;
                    w_clr          = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt    = ST_FILL;
                w_tx_valid_nxt = 1'b0;
                w_tx_data_nxt  = 8'h00;
                w_clr          = 1'b1;
            end
        endcase
    end

    assign in_ready = (r_state == ST_FILL);
    assign busy     = (r_state != ST_FILL);
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign trunc    = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_amx_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_amx_frame_tx
// Brief   : Scoreboard bench for amx_frame_tx; frame model follows the
//           AMX_FRAME_TX_CSUM_EN build option.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_amx_frame_tx;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SOF     = 8'hA5;
`ifdef AMX_FRAME_TX_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       trunc;

    amx_frame_tx #(.MAX_LEN(MAX_LEN), .SOF_BYTE(SOF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .trunc    (trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         eof;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cur_q[$];
    int tests = 0, fails = 0;
    int trunc_exp = 0, trunc_seen = 0, pops = 0;
    int tx_mode = 0;
    bit idle_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a frame is the bytes since the previous close, cut at
    // in_last or at MAX_LEN; wire image is SOF, length, payload, [xor of all].
    task automatic model_byte(input logic [7:0] d, input bit last, output bit closed);
        exp_t       f[$];
        exp_t       e;
        logic [7:0] x;
        cur_q.push_back(d);
        closed = last || (cur_q.size() == MAX_LEN);
        if (closed) begin
            if (!last) trunc_exp++;
            x = 8'(cur_q.size());
            e.eof = 1'b0;
            e.data = SOF; f.push_back(e);
            e.data = x;   f.push_back(e);
            foreach (cur_q[i]) begin
                e.data = cur_q[i];
                f.push_back(e);
                x = x ^ cur_q[i];
            end
            if (CSUM_EN) begin
                e.data = x;
                f.push_back(e);
            end
            f[f.size()-1].eof = 1'b1;
            foreach (f[i]) exp_q.push_back(f[i]);
            cur_q.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        bit closed;
        bit acc;
        int guard;
        if (idle_en && ($urandom_range(0, 3) == 0)) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        model_byte(d, last, closed);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: byte 0x%0h never accepted", d);
        end else if (closed) begin
            @(negedge clk);
            check("sof_latency", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, SOF});
        end
    endtask

    task automatic send_test1();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Sink-side ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard.
    bit         stall_v = 1'b0;
    logic [7:0] stall_d = 8'h00;
    bit         post_eof = 1'b0;
    logic       trunc_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_v    = 1'b0;
            post_eof   = 1'b0;
            trunc_prev = 1'b0;
        end else begin
            if (post_eof) begin
                check("post_frame_idle", {29'd0, in_ready, busy, tx_valid}, 32'b100);
                post_eof = 1'b0;
            end
            if (stall_v) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_d});
            if (trunc) begin
                trunc_seen++;
                check("trunc_pulse", {22'd0, trunc_prev, tx_valid, tx_data}, {22'd0, 1'b0, 1'b1, SOF});
            end
            trunc_prev = trunc;
            if (tx_valid) check("busy_when_valid", {31'd0, busy}, 32'd1);
            stall_v = tx_valid && !tx_ready;
            stall_d = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, tx_data}, {24'd0, e.data});
                    pops++;
                    post_eof = e.eof;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, g, n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {26'd0, tx_valid, busy, trunc, in_ready, 2'b00}, 32'b000100);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk);
        #1;

        tx_mode = 0;
        send_test1();
        wait_drain();

        send_byte(8'h5A, 1'b1);
        wait_drain();

        tx_mode = 1;
        send_test1();
        wait_drain();

        tx_mode = 0;
        for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b0);
        send_byte(8'h77, 1'b1);
        wait_drain();

        // Reset in the middle of payload transmission.
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), i == 7);
        p0 = pops;
        g  = 0;
        while (pops < p0 + 3 && g < 500) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        check("pre_reset_pay", {30'd0, busy, tx_valid}, 32'b11);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        cur_q.delete();
        @(negedge clk);
        check("post_reset", {29'd0, tx_valid, in_ready, busy}, 32'b010);
        @(posedge clk);
        #1;
        send_test1();
        wait_drain();

        // Randomized frames, including exact-MAX_LEN and multi-chunk lengths.
        tx_mode = 2;
        idle_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            case (f)
                0:       n = MAX_LEN;
                1:       n = 2 * MAX_LEN;
                2:       n = MAX_LEN + 1;
                default: n = $urandom_range(1, 40);
            endcase
            for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1);
        end
        wait_drain();

        check("trunc_count", trunc_seen, trunc_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
